head_table_writer: RTL

Write-side master of the head-table write interface: accepts head-pointer update requests from the insert and delete engines, buffers each in its own FIFO, arbitrates round-robin and drives one registered RAM write per cycle into `head_table_if`. Sits between the data-table update logic and the head table, pausing writes while the head RAM is being cleared.

---
 rtl/head_table_writer_if.sv | 38 +++
 rtl/head_table_writer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/head_table_writer_if.sv
// Shared head-table types and the head RAM write interface.
// The writer drives it as master; the head table consumes it as slave.
package head_table_pkg;

    localparam int BUCKET_WIDTH = 8;

    typedef struct packed {
        logic       ptr_val;
        logic [7:0] ptr;
    } head_ram_data_t;

endpackage

interface head_table_if #(
    parameter int A_WIDTH = 8,
    parameter int P_WIDTH = 8
) ();

    logic [A_WIDTH-1:0] wr_addr;
    logic [P_WIDTH-1:0] wr_data_ptr;
    logic               wr_data_ptr_val;
    logic               wr_en;

    modport master (
        output wr_addr,
        output wr_data_ptr,
        output wr_data_ptr_val,
        output wr_en
    );

    modport slave (
        input wr_addr,
        input wr_data_ptr,
        input wr_data_ptr_val,
        input wr_en
    );

endinterface

// File: rtl/head_table_writer.sv
// head_table_writer: buffers insert/delete head-pointer updates in two FIFOs,
// arbitrates round-robin and issues one registered head RAM write per cycle.
// Ports: clk_i/rst_i (async, active-high); ins_*/del_* request channels with
// valid/ready; ht_if (head_table_if.master) write port; clear_busy_i pauses
// arbitration; busy_o = work outstanding; wr_cnt_o = issued write count.

module head_table_writer_fifo #(
    parameter int W     = 17,
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       i_push,
    input  logic [W-1:0]               i_data,
    input  logic                       i_pop,
    output logic [W-1:0]               o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [CW-1:0] r_cnt;

    logic w_push;
    logic w_pop;

    assign o_full  = (r_cnt == CW'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign o_cnt   = r_cnt;
    assign o_data  = r_mem[r_rp];

    // A push is refused on full even if a pop happens the same cycle.
    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wp] <= i_data;
        end
    end

    // Depth is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wp <= r_wp + 1'b1;
            end
            if (w_pop) begin
                r_rp <= r_rp + 1'b1;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

module head_table_writer
    import head_table_pkg::*;
#(
    parameter int A_WIDTH    = BUCKET_WIDTH,
    parameter int P_WIDTH    = $bits(head_ram_data_t) - 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,

    input  logic [A_WIDTH-1:0] ins_bucket_i,
    input  logic [P_WIDTH-1:0] ins_ptr_i,
    input  logic               ins_ptr_val_i,
    input  logic               ins_valid_i,
    output logic               ins_ready_o,

    input  logic [A_WIDTH-1:0] del_bucket_i,
    input  logic [P_WIDTH-1:0] del_ptr_i,
    input  logic               del_ptr_val_i,
    input  logic               del_valid_i,
    output logic               del_ready_o,

    head_table_if.master       ht_if,

    input  logic               clear_busy_i,
    output logic               busy_o,
    output logic [15:0]        wr_cnt_o
);

    localparam int E  = A_WIDTH + P_WIDTH + 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic {
        PRIO_INS = 1'b0,
        PRIO_DEL = 1'b1
    } prio_e;

    prio_e r_prio;

    logic [E-1:0]  w_ins_din;
    logic [E-1:0]  w_del_din;
    logic [E-1:0]  w_ins_dout;
    logic [E-1:0]  w_del_dout;
    logic [E-1:0]  w_pop_data;
    logic          w_ins_full;
    logic          w_del_full;
    logic          w_ins_empty;
    logic          w_del_empty;
    logic [CW-1:0] w_ins_cnt;
    logic [CW-1:0] w_del_cnt;
    logic          w_gnt_ins;
    logic          w_gnt_del;

    logic [A_WIDTH-1:0] r_wr_addr;
    logic [P_WIDTH-1:0] r_wr_ptr;
    logic               r_wr_ptr_val;
    logic               r_wr_en;
    logic [15:0]        r_wr_cnt;

    assign w_ins_din = {ins_bucket_i, ins_ptr_i, ins_ptr_val_i};
    assign w_del_din = {del_bucket_i, del_ptr_i, del_ptr_val_i};

    assign ins_ready_o = !w_ins_full;
    assign del_ready_o = !w_del_full;

    head_table_writer_fifo #(
        .W     (E),
        .DEPTH (FIFO_DEPTH)
    ) u_ins_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_push  (ins_valid_i),
        .i_data  (w_ins_din),
        .i_pop   (w_gnt_ins),
        .o_data  (w_ins_dout),
        .o_full  (w_ins_full),
        .o_empty (w_ins_empty),
        .o_cnt   (w_ins_cnt)
    );

    head_table_writer_fifo #(
        .W     (E),
        .DEPTH (FIFO_DEPTH)
    ) u_del_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_push  (del_valid_i),
        .i_data  (w_del_din),
        .i_pop   (w_gnt_del),
        .o_data  (w_del_dout),
        .o_full  (w_del_full),
        .o_empty (w_del_empty),
        .o_cnt   (w_del_cnt)
    );

    // Round-robin: a lone non-empty FIFO always wins; on contention the
    // prio channel wins. Nothing is granted while the RAM is being cleared.
    always_comb begin
        w_gnt_ins = 1'b0;
        w_gnt_del = 1'b0;
        if (!clear_busy_i) begin
            if (!w_ins_empty && (w_del_empty || r_prio == PRIO_INS)) begin
                w_gnt_ins = 1'b1;
            end else if (!w_del_empty) begin
                w_gnt_del = 1'b1;
            end
        end
    end

    assign w_pop_data = w_gnt_del ? w_del_dout : w_ins_dout;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_prio <= PRIO_INS;
        end else if (w_gnt_ins) begin
            r_prio <= PRIO_DEL;
        end else if (w_gnt_del) begin
            r_prio <= PRIO_INS;
        end
    end

    // Address/data hold their last value when nothing is granted.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_ptr     <= '0;
            r_wr_ptr_val <= 1'b0;
        end else begin
            r_wr_en <= w_gnt_ins || w_gnt_del;
            if (w_gnt_ins || w_gnt_del) begin
                r_wr_addr    <= w_pop_data[E-1 -: A_WIDTH];
                r_wr_ptr     <= w_pop_data[P_WIDTH:1];
                r_wr_ptr_val <= w_pop_data[0];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_cnt <= '0;
        end else if (r_wr_en) begin
            r_wr_cnt <= r_wr_cnt + 16'd1;
        end
    end

    assign ht_if.wr_addr         = r_wr_addr;
    assign ht_if.wr_data_ptr     = r_wr_ptr;
    assign ht_if.wr_data_ptr_val = r_wr_ptr_val;
    assign ht_if.wr_en           = r_wr_en;

    assign busy_o   = (w_ins_cnt != '0) || (w_del_cnt != '0) || r_wr_en;
    assign wr_cnt_o = r_wr_cnt;

endmodule
